serial_parity_rx: RTL

- Bit-serial frame receiver with parity checking: it is the receiving end of a serial transmitter that emits a start bit, data bits, a parity bit and a stop bit.
- It samples one bit per bit_en strobe, deserialises data LSB first, checks parity and framing, and holds the received word until a ready/valid consumer accepts it.
- It is a synthesis and backend test block in the logic/FSM test group, exercising flops, reduction XOR/XNOR, comparisons and nested conditionals.

---
 rtl/serial_parity_rx_pkg.sv | 22 ++
 rtl/serial_parity_rx_out_buffer.sv | 48 ++++
 rtl/serial_parity_rx.sv | 101 ++++++++++
 3 files changed

// File: rtl/serial_parity_rx_pkg.sv
// Shared types and line-level constants for the serial parity receiver.
package serial_parity_rx_pkg;

    // Receiver FSM states; encodings are fixed so they are stable in netlists.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } rx_state_e;

    // Line level while idle (and for a good stop bit) and level of a start bit.
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // True when the XOR of data and parity bit disagrees with the chosen sense.
    function automatic logic parity_bad(input logic data_xor, input logic p_bit,
                                        input logic odd);
        return (data_xor ^ p_bit) != odd;
    endfunction

endpackage

// File: rtl/serial_parity_rx_out_buffer.sv
// Single-entry valid/ready holding register with sticky overrun detection.
module rx_out_buffer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              commit_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              parity_err_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              parity_err_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              overrun_q;

    // Load on commit when the slot is free or being drained this cycle; otherwise
    // keep the held word and flag the drop. A handshake alone empties the slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (commit_i) begin
            if (!valid_q || ready_i) begin
                data_q  <= data_i;
                perr_q  <= parity_err_i;
                valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = overrun_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Bit-serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
module serial_parity_rx
    import serial_parity_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              bit_en_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_in;
    logic              p_bit_q;
    logic              frame_err_q;
    logic              commit;
    logic              commit_perr;

    // Next shift value: new bit enters at the MSB so the first bit ends at bit 0.
    always_comb begin
        shift_in             = shift_q >> 1;
        shift_in[DATA_W-1]   = rx_i;
    end

    // A good stop sample hands the frame to the output buffer on the same edge.
    assign commit      = bit_en_i && (state_q == StStop) && (rx_i == IDLE_LEVEL);
    assign commit_perr = parity_bad(^shift_q, p_bit_q, PARITY_ODD);

    // Frame FSM; everything advances only on bit_en strobes, frame_err is a pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            p_bit_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (bit_en_i) begin
                unique case (state_q)
                    StIdle: begin
                        if (rx_i == START_LEVEL) begin
                            state_q <= StData;
                            cnt_q   <= '0;
                        end
                    end
                    StData: begin
                        shift_q <= shift_in;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        p_bit_q <= rx_i;
                        state_q <= StStop;
                    end
                    StStop: begin
                        if (rx_i != IDLE_LEVEL) begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    rx_out_buffer #(
        .DATA_W (DATA_W)
    ) u_out_buffer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .commit_i     (commit),
        .data_i       (shift_q),
        .parity_err_i (commit_perr),
        .ready_i      (out_ready_i),
        .data_o       (out_data_o),
        .valid_o      (out_valid_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o)
    );

    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != StIdle);

endmodule
